ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader.sv | 104 ++++++++++
 tb/tb_ram_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// Byte-stream to 16-bit word memory loader: gathers little-endian byte pairs,
// writes them to sequential addresses and keeps a running 16-bit checksum.
module ram_loader #(
    parameter int AW    = 11,
    parameter int DEPTH = 2048
) (
    input  logic          clk,
    input  logic          resetq,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic          busy,
    output logic          done,
    output logic [15:0]   checksum
);

    typedef enum logic [2:0] {IDLE, LO, HI, WR, DONE} state_t;

    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
    localparam logic [AW:0] ONE_W   = {{AW{1'b0}}, 1'b1};

    state_t      state;
    state_t      state_next;
    logic [AW:0] remaining;
    logic        launch;
    logic        take;
    logic        last;

    assign launch = start && (state == IDLE || state == DONE);
    assign take   = rx_valid && rx_ready;
    assign last   = (remaining == ONE_W);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) state_next = LO;
            end
            LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) state_next = HI;
            end
            HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) state_next = WR;
            end
            WR: begin
                wr_en      = 1'b1;
                busy       = 1'b1;
                state_next = last ? DONE : LO;
            end
            default: state_next = IDLE;
        endcase
    end

    // Lengths of zero or beyond the memory size load the whole memory, so the
    // address counter can never wrap past DEPTH-1.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            remaining <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            checksum  <= '0;
            done      <= 1'b0;
        end else begin
            if (launch) begin
                remaining <= (len == '0 || len > DEPTH_W) ? DEPTH_W : len;
                wr_addr   <= '0;
                checksum  <= '0;
                done      <= 1'b0;
            end
            if (take && state == LO) wr_data[7:0]  <= rx_data;
            if (take && state == HI) wr_data[15:8] <= rx_data;
            if (state == WR) begin
                checksum  <= checksum + wr_data;
                remaining <= remaining - ONE_W;
                if (last) begin
                    done <= 1'b1;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Randomized self-checking bench for ram_loader: a word-level reference model
// built from the byte list is compared against every captured memory write.
module tb_ram_loader;

    localparam int AW    = 11;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          resetq = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          busy;
    logic          done;
    logic [15:0]   checksum;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0]    tx[$];
    logic [AW-1:0] cap_addr[$];
    logic [15:0]   cap_data[$];
    int            cap_cyc[$];
    logic [AW-1:0] ref_addr[$];
    logic [15:0]   ref_data[$];

    ram_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .resetq   (resetq),
        .start    (start),
        .len      (len),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (wr_en === 1'b1) begin
            cap_addr.push_back(wr_addr);
            cap_data.push_back(wr_data);
            cap_cyc.push_back(cyc);
            check("ready_in_wr", {31'd0, rx_ready}, 32'd0);
        end
    end

    task automatic clear_capture();
        cap_addr.delete();
        cap_data.delete();
        cap_cyc.delete();
    endtask

    task automatic make_bytes(input int n);
        tx.delete();
        for (int i = 0; i < n; i++) tx.push_back(8'($urandom_range(255)));
    endtask

    task automatic start_load(input int l);
        @(negedge clk);
        start = 1'b1;
        len   = (AW+1)'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams tx; gap_pct is the chance of an idle cycle, start_at injects a
    // stray start pulse alongside that byte index (-1 for none).
    task automatic send_bytes(input int gap_pct, input int start_at);
        int  i = 0;
        int  guard = 0;
        bit  pulsed = 1'b0;
        while (i < tx.size()) begin
            @(negedge clk);
            start = 1'b0;
            guard++;
            if (guard > 20000) begin
                check("send_timeout", 32'(i), 32'(tx.size()));
                break;
            end
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom_range(255));
            end else begin
                rx_valid = 1'b1;
                rx_data  = tx[i];
                if (i == start_at && !pulsed) begin
                    start  = 1'b1;
                    len    = (AW+1)'(1);
                    pulsed = 1'b1;
                end
                #1;
                if (rx_ready === 1'b1) i++;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 100), 32'd1);
    endtask

    task automatic check_load(input int nwords);
        logic [15:0] w;
        logic [15:0] last_w;
        int          sum = 0;
        wait_idle();
        check("n_writes", 32'(cap_addr.size()), 32'(nwords));
        for (int i = 0; i < nwords; i++) begin
            w   = {tx[2*i+1], tx[2*i]};
            sum = (sum + int'(w)) % 65536;
            if (i < cap_addr.size()) begin
                check("addr_seq", 32'(cap_addr[i]), 32'(i));
                check("data_seq", 32'(cap_data[i]), 32'(w));
            end
        end
        last_w = {tx[2*nwords-1], tx[2*nwords-2]};
        check("checksum", 32'(checksum), 32'(sum));
        check("done", 32'(done), 32'd1);
        check("busy", 32'(busy), 32'd0);
        check("last_addr", 32'(wr_addr), 32'(nwords - 1));
        check("last_data", 32'(wr_data), 32'(last_w));
        repeat (4) @(negedge clk);
        check("hold_addr", 32'(wr_addr), 32'(nwords - 1));
        check("hold_data", 32'(wr_data), 32'(last_w));
        check("hold_checksum", 32'(checksum), 32'(sum));
        check("hold_done", 32'(done), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},    32'(wr_en),    32'd0);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
        check({tag, "_wr_data"},  32'(wr_data),  32'd0);
        check({tag, "_checksum"}, 32'(checksum), 32'd0);
    endtask

    initial begin
        // Reset state
        #3 resetq = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        #2 resetq = 1'b1;

        // Directed two-word load
        clear_capture();
        tx = '{8'h34, 8'h12, 8'h78, 8'h56};
        start_load(2);
        send_bytes(0, -1);
        check_load(2);
        check("cs_directed", 32'(checksum), 32'h68AC);

        // Continuous rx_valid: 3-cycle spacing
        clear_capture();
        make_bytes(12);
        start_load(6);
        send_bytes(0, -1);
        check_load(6);
        for (int i = 1; i < cap_cyc.size(); i++)
            check("spacing", 32'(cap_cyc[i] - cap_cyc[i-1]), 32'd3);
        ref_addr = cap_addr;
        ref_data = cap_data;

        // Same bytes with random gaps must produce the same writes
        clear_capture();
        start_load(6);
        send_bytes(40, -1);
        check_load(6);
        check("gap_count", 32'(cap_addr.size()), 32'(ref_addr.size()));
        for (int i = 0; i < ref_addr.size() && i < cap_addr.size(); i++) begin
            check("gap_addr", 32'(cap_addr[i]), 32'(ref_addr[i]));
            check("gap_data", 32'(cap_data[i]), 32'(ref_data[i]));
        end

        // Stray start mid-load is ignored
        for (int k = 0; k < 2; k++) begin
            clear_capture();
            make_bytes(10);
            start_load(5);
            send_bytes(20, 3 + k * 2);
            check_load(5);
        end

        // Full-memory load via len=0
        clear_capture();
        make_bytes(2 * DEPTH);
        start_load(0);
        send_bytes(0, -1);
        check_load(DEPTH);
        @(negedge clk);
        rx_valid = 1'b1;
        repeat (20) @(negedge clk);
        rx_valid = 1'b0;
        check("no_write_after_full", 32'(cap_addr.size()), 32'(DEPTH));
        check("full_last_addr", 32'(cap_addr[cap_addr.size()-1]), 32'(DEPTH - 1));

        // Reset after the low byte of the fifth word
        clear_capture();
        make_bytes(9);
        start_load(8);
        send_bytes(0, -1);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 resetq = 1'b0;
        #1 check_all_zero("midreset");
        repeat (3) @(negedge clk);
        #2 resetq = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_writes", 32'(cap_addr.size()), 32'd4);
        check("midreset_idle_busy", 32'(busy), 32'd0);
        clear_capture();
        make_bytes(6);
        start_load(3);
        send_bytes(25, -1);
        check_load(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
